sc_level_speed_timer: RTL and testbench

SC_LEVEL_SPEED_TIMER -- requirements
Module: sc_level_speed_timer

---
 rtl/sc_level_speed_timer.sv | 114 +++++++++++
 tb/tb_sc_level_speed_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_level_speed_timer.sv
// Level-dependent move-tick generator: the tick period shrinks as the level rises,
// and a level change reloads the period and restarts the count from zero.
module sc_level_speed_timer #(
    parameter int LEVEL_WIDTH  = 3,
    parameter int PERIOD_WIDTH = 26,
    parameter int BASE_PERIOD  = 25000000,
    parameter int STEP_PERIOD  = 3000000,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                    SC_levelcounter_CLOCK_50,
    input  logic                    SC_levelcounter_RESET_InHigh,
    input  logic [LEVEL_WIDTH-1:0]  SC_levelspeed_level_InBus,
    input  logic                    SC_levelspeed_run_InLow,
    output logic                    SC_levelspeed_tick_OutLow,
    output logic                    SC_levelspeed_levelchange_OutLow,
    output logic [PERIOD_WIDTH-1:0] SC_levelspeed_period_OutBus
);

    // state    | meaning
    // STOPPED  | count held at 0, no ticks
    // RUNNING  | counting, tick on terminal count
    // RELOAD   | one cycle after a level change, count held at 0
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_RELOAD  = 2'd2
    } state_t;

    // Extra headroom so level*step never wraps before the clamp compare.
    localparam int CALC_W  = PERIOD_WIDTH + LEVEL_WIDTH + 2;
    localparam int MIN_EFF = (MIN_PERIOD < 2) ? 2 : MIN_PERIOD;

    localparam logic [CALC_W-1:0] BASE_W = CALC_W'(BASE_PERIOD);
    localparam logic [CALC_W-1:0] STEP_W = CALC_W'(STEP_PERIOD);
    localparam logic [CALC_W-1:0] MIN_W  = CALC_W'(MIN_EFF);

    function automatic logic [PERIOD_WIDTH-1:0] period_of(input logic [LEVEL_WIDTH-1:0] lvl);
        logic [CALC_W-1:0] reduction;
        reduction = CALC_W'(lvl) * STEP_W;
        if (reduction + MIN_W >= BASE_W)
            period_of = PERIOD_WIDTH'(MIN_W);
        else
            period_of = PERIOD_WIDTH'(BASE_W - reduction);
    endfunction

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_L0 = period_of(LEVEL_WIDTH'(0));

    state_t                  state_q;
    logic [LEVEL_WIDTH-1:0]  level_q;
    logic [PERIOD_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    tick_q;
    logic                    levelchange_q;

    logic level_change;
    logic terminal;

    assign level_change = (SC_levelspeed_level_InBus != level_q);
    assign terminal     = (count_q == period_q - PERIOD_WIDTH'(1));

    always_ff @(posedge SC_levelcounter_CLOCK_50 or posedge SC_levelcounter_RESET_InHigh) begin
        if (SC_levelcounter_RESET_InHigh) begin
            state_q       <= ST_STOPPED;
            level_q       <= '0;
            count_q       <= '0;
            period_q      <= PERIOD_L0;
            tick_q        <= 1'b1;
            levelchange_q <= 1'b1;
        end else begin
            level_q       <= SC_levelspeed_level_InBus;
            tick_q        <= 1'b1;
            levelchange_q <= 1'b1;
            // A level change outranks run and terminal count, so a coincident tick is dropped.
            if (level_change) begin
                state_q       <= ST_RELOAD;
                period_q      <= period_of(SC_levelspeed_level_InBus);
                count_q       <= '0;
                levelchange_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_STOPPED: begin
                        count_q <= '0;
                        if (!SC_levelspeed_run_InLow)
                            state_q <= ST_RUNNING;
                    end
                    ST_RUNNING: begin
                        if (SC_levelspeed_run_InLow) begin
                            state_q <= ST_STOPPED;
                            count_q <= '0;
                        end else if (terminal) begin
                            count_q <= '0;
                            tick_q  <= 1'b0;
                        end else begin
                            count_q <= count_q + PERIOD_WIDTH'(1);
                        end
                    end
                    ST_RELOAD: begin
                        count_q <= '0;
                        state_q <= SC_levelspeed_run_InLow ? ST_STOPPED : ST_RUNNING;
                    end
                    default: begin
                        state_q <= ST_STOPPED;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign SC_levelspeed_tick_OutLow        = tick_q;
    assign SC_levelspeed_levelchange_OutLow = levelchange_q;
    assign SC_levelspeed_period_OutBus      = period_q;

endmodule

// File: tb/tb_sc_level_speed_timer.sv
// Bench for sc_level_speed_timer: directed literal checks plus randomized stimulus
// compared every cycle against a cycle-index/modulo model of the tick schedule.
module tb_sc_level_speed_timer;

    localparam int LW   = 3;
    localparam int PW   = 8;
    localparam int BASE = 10;
    localparam int STEP = 2;
    localparam int MINP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LW-1:0] lvl = '0;
    logic          run_n = 1'b1;
    logic          tick_n;
    logic          lc_n;
    logic [PW-1:0] per;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sc_level_speed_timer #(
        .LEVEL_WIDTH (LW),
        .PERIOD_WIDTH(PW),
        .BASE_PERIOD (BASE),
        .STEP_PERIOD (STEP),
        .MIN_PERIOD  (MINP)
    ) dut (
        .SC_levelcounter_CLOCK_50        (clk),
        .SC_levelcounter_RESET_InHigh    (rst),
        .SC_levelspeed_level_InBus       (lvl),
        .SC_levelspeed_run_InLow         (run_n),
        .SC_levelspeed_tick_OutLow       (tick_n),
        .SC_levelspeed_levelchange_OutLow(lc_n),
        .SC_levelspeed_period_OutBus     (per)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int period_fn(input int l);
        int p;
        p = BASE - l * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    // Reference model: ticks fall on multiples of the period measured from the cycle counting began.
    int m_n, m_start, m_prev, m_period;
    bit m_counting, m_reloading, e_tick, e_lc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_start = 0; m_prev = 0;
            m_period = period_fn(0);
            m_counting = 0; m_reloading = 0;
            e_tick = 1; e_lc = 1;
        end else begin
            m_n++;
            e_tick = 1;
            e_lc = 1;
            if (int'(lvl) != m_prev) begin
                m_prev = int'(lvl);
                m_period = period_fn(m_prev);
                m_reloading = 1;
                m_counting = 0;
                e_lc = 0;
            end else if (m_reloading || !m_counting) begin
                m_reloading = 0;
                if (!run_n) begin
                    m_counting = 1;
                    m_start = m_n;
                end
            end else if (run_n) begin
                m_counting = 0;
            end else if ((m_n - m_start) % m_period == 0) begin
                e_tick = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tick", tick_n, e_tick);
            chk("model_levelchange", lc_n, e_lc);
            chk("model_period", per, m_period);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lows;
        int lcs;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) step();
        chk("reset_tick", tick_n, 1);
        chk("reset_levelchange", lc_n, 1);
        chk("reset_period", per, 10);

        // Run from level 0: ticks 10, 20, 30 cycles after entry edge.
        @(negedge clk);
        rst = 1'b0;
        run_n = 1'b0;
        step();
        lows = 0; lcs = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (!tick_n) lows++;
            if (!lc_n) lcs++;
            if (k % 10 == 0) chk("tick_at_base_period", tick_n, 0);
        end
        chk("ticks_in_30", lows, 3);
        chk("no_levelchange_lvl0", lcs, 0);

        // Level 0->3 at count 5.
        repeat (5) step();
        lvl = 3'd3;
        step();
        chk("lc_pulse_3", lc_n, 0);
        chk("period_lvl3", per, 4);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("tick_after_lvl3", tick_n, (k == 5 || k == 9) ? 0 : 1);
        end

        // Clamp levels.
        lvl = 3'd4;
        step();
        chk("period_lvl4", per, 3);
        lvl = 3'd7;
        step();
        chk("period_lvl7", per, 3);
        chk("lc_pulse_7", lc_n, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 4 || k == 7) chk("tick_period3", tick_n, 0);
            if (k == 5) chk("no_tick_mid3", tick_n, 1);
        end

        // Wrap 7->0, then change level on the cycle count reaches 9.
        lvl = 3'd0;
        step();
        chk("period_wrap", per, 10);
        repeat (9) step();
        lvl = 3'd1;
        step();
        chk("coincident_no_tick", tick_n, 1);
        chk("coincident_lc", lc_n, 0);
        chk("period_lvl1", per, 8);
        repeat (8) step();
        chk("no_tick_before_first", tick_n, 1);
        step();
        chk("first_tick_lvl1", tick_n, 0);

        // Stop at count 6 for 20 cycles, then resume.
        lvl = 3'd0;
        step();
        repeat (7) step();
        run_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!tick_n) lows++;
        end
        chk("no_tick_stopped", lows, 0);
        run_n = 1'b0;
        step();
        repeat (9) step();
        chk("no_tick_before_resume10", tick_n, 1);
        step();
        chk("tick_resume10", tick_n, 0);

        // Async reset right after a levelchange pulse begins.
        lvl = 3'd3;
        @(posedge clk);
        #1 chk("lc_before_reset", lc_n, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_lc", lc_n, 1);
        chk("async_tick", tick_n, 1);
        chk("async_period", per, 10);

        // Nonzero level at release gives one pulse.
        lvl = 3'd5;
        run_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("release_lc", lc_n, 0);
        chk("release_period", per, 3);
        step();
        chk("release_lc_once", lc_n, 1);
        chk("release_stopped", tick_n, 1);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            #1;
            if (rst) rst = 1'b0;
            r = int'($urandom_range(0, 199));
            if (r < 5) lvl = LW'($urandom);
            else if (r < 9) run_n = ~run_n;
            else if (r == 9 && i > 100) rst = 1'b1;
            else if (r > 150 && r < 155) run_n = 1'b0;
        end
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
